// File: rtl/mem_req_arb_mux_pkg.sv
// Shared types for the memory request arbiter/mux.
package mem_arb_pkg;

   // How the next winner is chosen among valid channels.
   typedef enum logic {
      ARB_FIXED = 1'b0,   // lowest valid index always wins
      ARB_RR    = 1'b1    // rotating start pointer, one past the last winner
   } arb_mode_e;

   // Occupancy of the single-entry output register.
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_e;

endpackage

// File: rtl/mem_req_arb_mux_rr_pick.sv
// Combinational rotating picker: first set bit of req at or after start,
// wrapping from N-1 back to 0. Returns a one-hot grant and its index.
module rr_pick #(
   parameter int N  = 2,
   parameter int CW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [CW-1:0] start,
   output logic [N-1:0]  gnt,
   output logic [CW-1:0] idx,
   output logic          any
);

   int k;

   // Walk the channels in priority order starting at 'start'; first hit wins.
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      k   = 0;
      for (int i = 0; i < N; i++) begin
         // start is always < N, so one subtraction gives the modulo-N wrap
         k = int'(start) + i;
         if (k >= N) begin
            k = k - N;
         end
         if (!any && req[k]) begin
            gnt[k] = 1'b1;
            idx    = CW'(k);
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_req_arb_mux.sv
// N-channel registered request mux in front of a single memory port.
// Picks one valid channel (fixed priority or round-robin), captures its
// address into a one-entry output register and holds it until memory accepts.
module mem_req_arb_mux
   import mem_arb_pkg::*;
#(
   parameter  int        WIDTH    = 64,
   parameter  int        NUM_CH   = 2,
   parameter  arb_mode_e ARB_MODE = ARB_RR,
   localparam int        CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [NUM_CH-1:0]       i_req_valid,
   input  logic [NUM_CH*WIDTH-1:0] i_req_addr,
   output logic [NUM_CH-1:0]       o_req_ready,
   output logic                    o_mem_valid,
   output logic [WIDTH-1:0]        o_mem_addr,
   output logic [CH_W-1:0]         o_mem_ch,
   input  logic                    i_mem_ready
);

   logic [WIDTH-1:0]  addr_arr [NUM_CH];

   out_state_e        state_reg;
   out_state_e        state_next;
   logic [WIDTH-1:0]  addr_reg;
   logic [CH_W-1:0]   ch_reg;
   logic [CH_W-1:0]   ptr_reg;
   logic [CH_W-1:0]   ptr_next;

   logic [CH_W-1:0]   pick_start;
   logic [NUM_CH-1:0] pick_gnt;
   logic [CH_W-1:0]   pick_idx;
   logic              pick_any;
   logic              can_load;
   logic              grant;

   // Unpack the flat address bus into one word per channel.
   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_addr_unpack
         assign addr_arr[gi] = i_req_addr[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Fixed priority is just the rotating search pinned to start at channel 0.
   assign pick_start = (ARB_MODE == ARB_RR) ? ptr_reg : '0;

   rr_pick #(
      .N  (NUM_CH),
      .CW (CH_W)
   ) u_pick (
      .req   (i_req_valid),
      .start (pick_start),
      .gnt   (pick_gnt),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // The register may take a new entry when empty or when its current entry
   // leaves this cycle. Ready is derived from valid, never the other way round.
   assign can_load    = (state_reg == EMPTY) || i_mem_ready;
   assign grant       = can_load && pick_any && !i_rst;
   assign o_req_ready = grant ? pick_gnt : '0;

   assign o_mem_valid = (state_reg == FULL);
   assign o_mem_addr  = addr_reg;
   assign o_mem_ch    = ch_reg;

   // Output-register occupancy: fill on grant, drain on accept without refill.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         EMPTY: begin
            if (grant) begin
               state_next = FULL;
            end
         end
         FULL: begin
            if (i_mem_ready && !grant) begin
               state_next = EMPTY;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   // Round-robin pointer moves one past the winner, wrapping modulo NUM_CH.
   always_comb begin
      ptr_next = ptr_reg;
      if (grant) begin
         if (pick_idx == CH_W'(NUM_CH - 1)) begin
            ptr_next = '0;
         end else begin
            ptr_next = pick_idx + 1'b1;
         end
      end
   end

   // State, pointer and captured request; reset drops any held entry.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg <= EMPTY;
         addr_reg  <= '0;
         ch_reg    <= '0;
         ptr_reg   <= '0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         if (grant) begin
            addr_reg <= addr_arr[pick_idx];
            ch_reg   <= pick_idx;
         end
      end
   end

endmodule

// File: tb/tb_mem_req_arb_mux.sv
// Directed bench for mem_req_arb_mux: a 2-channel round-robin instance driven
// from a vector table plus hand sequences, and 3-channel RR / fixed instances
// for the arbitration order.
module tb_mem_req_arb_mux;
   import mem_arb_pkg::*;

   localparam int W = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // 2-channel round-robin instance
   logic [1:0]   req_valid;
   logic [2*W-1:0] req_addr;
   logic [1:0]   req_ready;
   logic         mem_valid;
   logic [W-1:0] mem_addr;
   logic         mem_ch;
   logic         mem_ready;

   mem_req_arb_mux #(.WIDTH(W), .NUM_CH(2), .ARB_MODE(ARB_RR)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_valid (req_valid),
      .i_req_addr  (req_addr),
      .o_req_ready (req_ready),
      .o_mem_valid (mem_valid),
      .o_mem_addr  (mem_addr),
      .o_mem_ch    (mem_ch),
      .i_mem_ready (mem_ready)
   );

   // 3-channel instances sharing one set of inputs
   logic [2:0]     v3_valid;
   logic [3*W-1:0] v3_addr;
   logic           v3_mready;
   logic [2:0]     rr3_ready, fx3_ready;
   logic           rr3_valid, fx3_valid;
   logic [W-1:0]   rr3_addr, fx3_addr;
   logic [1:0]     rr3_ch, fx3_ch;

   mem_req_arb_mux #(.WIDTH(W), .NUM_CH(3), .ARB_MODE(ARB_RR)) dut_rr3 (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_valid (v3_valid),
      .i_req_addr  (v3_addr),
      .o_req_ready (rr3_ready),
      .o_mem_valid (rr3_valid),
      .o_mem_addr  (rr3_addr),
      .o_mem_ch    (rr3_ch),
      .i_mem_ready (v3_mready)
   );

   mem_req_arb_mux #(.WIDTH(W), .NUM_CH(3), .ARB_MODE(ARB_FIXED)) dut_fx3 (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_valid (v3_valid),
      .i_req_addr  (v3_addr),
      .o_req_ready (fx3_ready),
      .o_mem_valid (fx3_valid),
      .o_mem_addr  (fx3_addr),
      .o_mem_ch    (fx3_ch),
      .i_mem_ready (v3_mready)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   // Drive 2-channel inputs just after a rising edge.
   task automatic drive2(input logic [1:0] v, input logic [W-1:0] a0, input logic [W-1:0] a1,
                         input logic mr);
      req_valid = v;
      req_addr  = {a1, a0};
      mem_ready = mr;
   endtask

   // Advance one clock, landing 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [1:0]   valid;
      logic [W-1:0] a0;
      logic [W-1:0] a1;
      logic         mr;
      logic [1:0]   exp_rdy;
      logic         exp_v;
      logic [W-1:0] exp_addr;
      logic         exp_ch;
   } vec_t;

   vec_t vecs [10];

   initial begin
      // Starting after reset: EMPTY, pointer 0.
      vecs[0] = '{2'b10, 64'h0,  64'h8000_0004, 1'b1, 2'b10, 1'b1, 64'h8000_0004, 1'b1}; // single req ch1, ptr->0
      vecs[1] = '{2'b00, 64'h0,  64'h0,         1'b1, 2'b00, 1'b0, 64'h8000_0004, 1'b1}; // drain, addr held
      vecs[2] = '{2'b11, 64'h10, 64'h20,        1'b1, 2'b01, 1'b1, 64'h10,        1'b0}; // ptr 0 -> ch0, ptr->1
      vecs[3] = '{2'b11, 64'h10, 64'h20,        1'b1, 2'b10, 1'b1, 64'h20,        1'b1}; // accept+reload ch1
      vecs[4] = '{2'b11, 64'h10, 64'h20,        1'b0, 2'b00, 1'b1, 64'h20,        1'b1}; // stall
      vecs[5] = '{2'b11, 64'h10, 64'h20,        1'b1, 2'b01, 1'b1, 64'h10,        1'b0}; // ch0, ptr->1
      vecs[6] = '{2'b01, 64'h14, 64'h20,        1'b1, 2'b01, 1'b1, 64'h14,        1'b0}; // ptr 1 wraps to ch0
      vecs[7] = '{2'b00, 64'h0,  64'h0,         1'b0, 2'b00, 1'b1, 64'h14,        1'b0}; // stall, no req
      vecs[8] = '{2'b00, 64'h0,  64'h0,         1'b1, 2'b00, 1'b0, 64'h14,        1'b0}; // accept, empty
      vecs[9] = '{2'b00, 64'h0,  64'h0,         1'b1, 2'b00, 1'b0, 64'h14,        1'b0}; // ready while empty ignored

      rst = 1'b1;
      drive2(2'b11, 64'hAA, 64'hBB, 1'b1);
      v3_valid  = 3'b111;
      v3_addr   = '0;
      v3_mready = 1'b1;

      // ---- Reset held 3 cycles with all valids high ----
      @(posedge clk);
      #1;
      for (int c = 0; c < 3; c++) begin
         #3;
         check($sformatf("reset c%0d req_ready", c), W'(req_ready), 64'h0);
         check($sformatf("reset c%0d rr3_ready", c), W'(rr3_ready), 64'h0);
         step();
         check($sformatf("reset c%0d mem_valid", c), W'(mem_valid), 64'h0);
         check($sformatf("reset c%0d mem_addr", c), mem_addr, 64'h0);
      end
      rst = 1'b0;
      drive2(2'b00, 64'h0, 64'h0, 1'b0);
      v3_valid = 3'b000;
      step();

      // ---- Vector table on the 2-channel RR instance ----
      for (int i = 0; i < 10; i++) begin
         drive2(vecs[i].valid, vecs[i].a0, vecs[i].a1, vecs[i].mr);
         #3;
         check($sformatf("vec%0d req_ready", i), W'(req_ready), W'(vecs[i].exp_rdy));
         step();
         check($sformatf("vec%0d mem_valid", i), W'(mem_valid), W'(vecs[i].exp_v));
         check($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].exp_addr);
         check($sformatf("vec%0d mem_ch", i), W'(mem_ch), W'(vecs[i].exp_ch));
      end

      // ---- Stall: ch0 loads 0x100, memory stalls 4 cycles while ch1 waits ----
      drive2(2'b01, 64'h100, 64'h0, 1'b0);
      #3;
      check("stall load req_ready", W'(req_ready), 64'h1);
      step();
      for (int c = 0; c < 4; c++) begin
         drive2(2'b10, 64'h0, 64'h200, 1'b0);
         #3;
         check($sformatf("stall c%0d req_ready", c), W'(req_ready), 64'h0);
         check($sformatf("stall c%0d mem_addr", c), mem_addr, 64'h100);
         check($sformatf("stall c%0d mem_valid", c), W'(mem_valid), 64'h1);
         step();
      end
      drive2(2'b10, 64'h0, 64'h200, 1'b1);
      #3;
      check("stall release req_ready", W'(req_ready), 64'h2);
      step();
      check("stall release mem_addr", mem_addr, 64'h200);
      check("stall release mem_ch", W'(mem_ch), 64'h1);

      // ---- Back-to-back stream from ch0 with memory always ready ----
      for (int c = 0; c < 3; c++) begin
         drive2(2'b01, W'(c * 4), 64'h0, 1'b1);
         #3;
         check($sformatf("b2b c%0d req_ready", c), W'(req_ready), 64'h1);
         step();
         check($sformatf("b2b c%0d mem_valid", c), W'(mem_valid), 64'h1);
         check($sformatf("b2b c%0d mem_addr", c), mem_addr, W'(c * 4));
      end
      drive2(2'b00, 64'h0, 64'h0, 1'b1);
      step();
      check("b2b drain mem_valid", W'(mem_valid), 64'h0);

      // ---- Reset while FULL and stalled; pointer left at 1 beforehand ----
      drive2(2'b01, 64'h300, 64'h0, 1'b1);
      step();
      drive2(2'b00, 64'h0, 64'h0, 1'b0);
      step();
      check("pre-reset held mem_valid", W'(mem_valid), 64'h1);
      rst = 1'b1;
      drive2(2'b11, 64'h400, 64'h500, 1'b0);
      #3;
      check("mid-reset req_ready", W'(req_ready), 64'h0);
      step();
      check("post-reset mem_valid", W'(mem_valid), 64'h0);
      rst = 1'b0;
      drive2(2'b11, 64'h400, 64'h500, 1'b1);
      #3;
      check("post-reset first grant", W'(req_ready), 64'h1);
      step();
      check("post-reset mem_addr", mem_addr, 64'h400);
      check("post-reset mem_ch", W'(mem_ch), 64'h0);
      drive2(2'b00, 64'h0, 64'h0, 1'b1);

      // ---- 3-channel fairness: RR cycles 0,1,2; fixed always 0 ----
      v3_valid  = 3'b111;
      v3_addr   = {64'h1002, 64'h1001, 64'h1000};
      v3_mready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #3;
         check($sformatf("rr3 c%0d req_ready", c), W'(rr3_ready), W'(3'b001 << (c % 3)));
         check($sformatf("fx3 c%0d req_ready", c), W'(fx3_ready), 64'h1);
         step();
         check($sformatf("rr3 c%0d mem_ch", c), W'(rr3_ch), W'(c % 3));
         check($sformatf("rr3 c%0d mem_addr", c), rr3_addr, W'(64'h1000 + c % 3));
         check($sformatf("fx3 c%0d mem_ch", c), W'(fx3_ch), 64'h0);
      end
      v3_valid = 3'b000;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
